// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and counter sizing for the serial subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter needs to index 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/ready/done operand and result bundle (ovf with SERIAL_SUB_OVERFLOW_EN)
interface serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         bin;
  logic         ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  modport master (
    output start, A, B, bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  ovf,
`endif
    input  ready, diff, bout, done
  );

  modport slave (
    input  start, A, B, bin,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output ovf,
`endif
    output ready, diff, bout, done
  );
endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - 1-bit full subtractor cell, mirror of the full-adder cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first, one bit per clock
// Optional signed overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic           br_q;
  logic [CW-1:0]  cnt_q;
  logic [N-2:0]   res_q;
  logic [N-1:0]   diff_q;
  logic           bout_q;
  logic           d_bit, br_next;
  logic [N-1:0]   res_shift;
  logic           accept, last_bit;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_next)
  );

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign last_bit  = (state_q == ST_RUN) && (cnt_q == LAST);
  assign res_shift = {d_bit, res_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      br_q  <= bus.bin;
      cnt_q <= '0;
    end else if (state_q == ST_RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      br_q  <= br_next;
      // res_q keeps only the N-1 low result bits; the MSB goes straight to diff.
      res_q <= res_shift[N-1:1];
      if (last_bit) begin
        cnt_q  <= '0;
        diff_q <= res_shift;
        bout_q <= br_next;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= bus.A[N-1];
      b_msb_q <= bus.B[N-1];
    end else if (last_bit) begin
      // d_bit is the result MSB on the final bit edge.
      ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (N=8)
module tb_serial_subtractor;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared   = 0;
  int mismatched = 0;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done (at most 20 cycles) and returns the cycle count after the start edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] exp_d, input logic exp_b,
                        input logic exp_o);
    int cyc;
    logic [7:0] old_diff;
    check({tag, "_ready_before"}, {31'd0, bus.ready}, 32'd1);
    old_diff = bus.diff;
    bus.A = a; bus.B = b; bus.bin = bi; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = ~a; bus.B = a ^ b; bus.bin = ~bi;
    check({tag, "_ready_run"}, {31'd0, bus.ready}, 32'd0);
    check({tag, "_diff_hold"}, {24'd0, bus.diff}, {24'd0, old_diff});
    wait_done(cyc);
    check({tag, "_latency"}, cyc, 32'd8);
    check({tag, "_diff"}, {24'd0, bus.diff}, {24'd0, exp_d});
    check({tag, "_bout"}, {31'd0, bus.bout}, {31'd0, exp_b});
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
`else
    if (exp_o) begin end
`endif
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, bus.ready}, 32'd1);
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int seen_done;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done",  {31'd0, bus.done},  32'd0);
    check("rst_diff",  {24'd0, bus.diff},  32'd0);
    check("rst_bout",  {31'd0, bus.bout},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1", 8'd100, 8'd37, 1'b0, 8'd63,  1'b0, 1'b0);
    run_op("t2", 8'd5,   8'd10, 1'b0, 8'hFB,  1'b1, 1'b0);
    run_op("t3a", 8'h00, 8'h00, 1'b1, 8'hFF,  1'b1, 1'b0);
    run_op("t3b", 8'hFF, 8'hFF, 1'b0, 8'h00,  1'b0, 1'b0);

    // start held high across an op; mid-run operand changes must not leak in
    bus.A = 8'h3C; bus.B = 8'h14; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.A = 8'h01; bus.B = 8'hF0;
    wait_done(cyc);
    check("t4_latency", cyc, 32'd8);
    check("t4_diff", {24'd0, bus.diff}, 32'h28);
    check("t4_bout", {31'd0, bus.bout}, 32'd0);
    bus.A = 8'hC8; bus.B = 8'h32;
    @(posedge clk);
    @(negedge clk);
    check("t4_ready_idle", {31'd0, bus.ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("t4_second_run", {31'd0, bus.ready}, 32'd0);
    wait_done(cyc);
    check("t4b_latency", cyc, 32'd8);
    check("t4b_diff", {24'd0, bus.diff}, 32'h96);
    check("t4b_bout", {31'd0, bus.bout}, 32'd0);
    @(negedge clk);

    // reset in the middle of a run
    bus.A = 8'hAA; bus.B = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_ready", {31'd0, bus.ready}, 32'd1);
    check("t5_diff",  {24'd0, bus.diff},  32'd0);
    check("t5_bout",  {31'd0, bus.bout},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    check("t5_no_done", seen_done, 32'd0);
    run_op("t5_fresh", 8'h40, 8'h41, 1'b1, 8'hFE, 1'b1, 1'b0);

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op("t6a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("t6b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
